bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the tri-state bus.
REQ-002 Parameter IDW, default 2: owner-index width; IDW SHALL equal ceil(log2(NREQ)).
REQ-003 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per tenure; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-low (rst=0 resets).
REQ-006 req  input  NREQ  per-requester bus request, level-sensitive.
REQ-007 gnt  output  NREQ  registered one-hot grant; the granted device alone drives its tri-state enable.
REQ-008 bus_busy  output  1  registered; equals OR of gnt.
REQ-009 owner  output  IDW  registered index of the granted requester; 0 when gnt=0.
REQ-010 timeout  output  1  registered one-cycle pulse when a tenure is ended by the MAX_HOLD limit.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT, TURN; encoding is free.
REQ-012 gnt SHALL be zero in IDLE and TURN and one-hot in GRANT; gnt SHALL never have two bits set.
REQ-013 Arbitration in IDLE and TURN: the winner is the first set bit of req, searching upward from pointer ptr and wrapping from NREQ-1 to 0.
REQ-014 IDLE: req=0 -> stay IDLE; req!=0 -> GRANT; gnt, owner and bus_busy take the winner on the same edge (1-cycle req-to-gnt latency).
REQ-015 GRANT: hold counter hcnt SHALL clear on entry and increment each cycle the owner keeps req high.
REQ-016 GRANT: req[owner]=0 at an edge -> TURN; gnt cleared on that edge; no timeout pulse.
REQ-017 GRANT: req[owner]=1 and hcnt=MAX_HOLD-1 -> TURN; gnt cleared; timeout=1 for the following cycle only.
REQ-018 The owner therefore SHALL hold gnt for at most MAX_HOLD cycles; MAX_HOLD=1 yields exactly one grant cycle per tenure.
REQ-019 On every GRANT->TURN transition, ptr SHALL become (owner+1) mod NREQ.
REQ-020 TURN SHALL last exactly one cycle with gnt=0 (bus-float turnaround preventing driver overlap), then arbitrate as in IDLE: req!=0 -> GRANT, else IDLE.
REQ-021 A requester keeping req high through TURN after timeout competes normally; a higher-ranked request from ptr wins.
REQ-022 req bits of non-owners SHALL be ignored while in GRANT; a request raised and dropped within one GRANT tenure SHALL be lost.
REQ-023 req changes between edges SHALL have no effect on outputs; all outputs are purely registered.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, gnt=0, owner=0, bus_busy=0, timeout=0, hcnt=0, ptr=0, regardless of clk, including mid-tenure.
REQ-025 After rst rises, the first edge with req!=0 SHALL grant per REQ-014 with ptr=0.

Verification (NREQ=4, MAX_HOLD=4)
REQ-026 req=4'b0010 for 3 cycles then 0 -> gnt=4'b0010 cycles 1-3, owner=1, bus_busy=1; then one cycle gnt=0 (TURN), then IDLE; timeout never set.
REQ-027 req=4'b1111 held constantly from reset -> gnt 0001,0010,0100,1000,0001 each for 4 cycles, one gnt=0 cycle between tenures, timeout pulse in each gap.
REQ-028 Priority/wrap: after owner 3 releases (ptr=0), req=4'b1001 -> gnt=4'b0001; after owner 1 releases (ptr=2), req=4'b1010 -> gnt=4'b1000.
REQ-029 Simultaneous: owner 2 drops req on the same edge that req0 rises (ptr becomes 3) -> TURN one cycle, then gnt=4'b0001.
REQ-030 Reset mid-tenure: gnt=4'b0100, drive rst=0 between clock edges -> gnt=0, owner=0, bus_busy=0 immediately; after release, req=4'b0100 -> gnt=4'b0100 one edge later.
REQ-031 Bench SHALL assert gnt is zero or one-hot every cycle and that no two consecutive tenures are adjacent without a gnt=0 cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for a shared tri-state bus. One requester at a time is
// granted the bus; every tenure ends with a one-cycle turnaround (TURN) in
// which nobody drives, so two tri-state drivers can never overlap. A tenure
// ends when the owner drops its request or after MAX_HOLD consecutive grant
// cycles. In the second case a one-cycle timeout pulse is raised.
//
// Handshake: req[i] is a level request. gnt[i] is the registered reply. The
// owner may drive the bus only while its gnt bit is high. It keeps req[i]
// high for as long as it wants the bus. Requests from other devices are not
// queued: a request that rises and falls while another device owns the bus
// is never seen.
//
// Parameters
//   NREQ      number of requesters
//   IDW       owner index width, equal to ceil(log2(NREQ))
//   MAX_HOLD  maximum consecutive grant cycles per tenure (1..255)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous reset, active low
//   req        per-requester request, level sensitive
//   gnt        registered one-hot grant (all zero when nobody owns the bus)
//   bus_busy   registered OR of gnt
//   owner      registered index of the granted requester, 0 when idle
//   timeout    registered one-cycle pulse when MAX_HOLD ends a tenure
//   fsm_state  current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            bus_busy,
  output logic [IDW-1:0]  owner,
  output logic            timeout,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [IDW-1:0]  owner_n;
  logic            busy_n;
  logic            timeout_n;
  logic [7:0]      hcnt, hcnt_n;
  logic [IDW-1:0]  ptr, ptr_n;

  // Arbitration result
  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [IDW:0]    scan;

  // Index following the current owner, wrapping NREQ-1 back to 0.
  logic [IDW-1:0]  owner_next;

  assign fsm_state  = state;
  assign owner_next = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);

  // Rotating priority search. It starts at ptr and wraps. One extra bit in
  // scan keeps ptr + i from overflowing before the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, ptr} + (IDW + 1)'(i);
      if (scan >= (IDW + 1)'(NREQ)) begin
        scan = scan - (IDW + 1)'(NREQ);
      end
      if (!win_found && req[scan[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDW-1:0];
      end
    end
  end

  // Next state and next outputs. All outputs are registered, so this block
  // computes the values that appear after the coming edge.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    owner_n   = owner;
    busy_n    = bus_busy;
    timeout_n = 1'b0;
    hcnt_n    = hcnt;
    ptr_n     = ptr;

    case (state)
      IDLE, TURN: begin
        if (win_found) begin
          state_n          = GRANT;
          gnt_n            = '0;
          gnt_n[win_idx]   = 1'b1;
          owner_n          = win_idx;
          busy_n           = 1'b1;
          hcnt_n           = '0;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          owner_n = '0;
          busy_n  = 1'b0;
        end
      end

      GRANT: begin
        // Only the owner's request matters here. Other req bits are ignored.
        if (!req[owner] || (hcnt == 8'(MAX_HOLD - 1))) begin
          state_n   = TURN;
          gnt_n     = '0;
          owner_n   = '0;
          busy_n    = 1'b0;
          hcnt_n    = '0;
          ptr_n     = owner_next;
          // Pulse only when the hold limit, not the owner, ended the tenure.
          timeout_n = req[owner];
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end

      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        owner_n = '0;
        busy_n  = 1'b0;
        hcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
      hcnt     <= '0;
      ptr      <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      bus_busy <= busy_n;
      timeout  <= timeout_n;
      hcnt     <= hcnt_n;
      ptr      <= ptr_n;
    end
  end

endmodule
